// File: rtl/half2fix_seq.sv
// Iterative IEEE-754 half-precision to signed Q(W-1-FRAC).FRAC decoder.
// Valid/ready on both sides; the magnitude is aligned by one bit per cycle.
module half2fix_seq #(
    parameter int W    = 32,
    parameter int FRAC = 30
) (
    input  logic         clk1,
    input  logic         F2X_rest,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_half,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_fixed,
    output logic         out_ovf,
    output logic         out_nan
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SIGN,
        DONE
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_mag;
    logic [5:0]        r_cnt;
    logic              r_left;
    logic              r_sign;
    logic              r_sat;
    logic              r_nan;

    logic              w_sign;
    logic [4:0]        w_exp;
    logic [9:0]        w_mant;
    logic [10:0]       w_sig;
    logic [4:0]        w_eeff;
    logic signed [7:0] w_sh;
    logic [5:0]        w_cnt;
    logic              w_zero;
    logic              w_inf;
    logic              w_nan;
    logic              w_ovf;
    logic              w_skip_shift;

    // Field decode and alignment distance; only consumed on the accept edge.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sign       = in_half[15];
        w_exp        = in_half[14:10];
        w_mant       = in_half[9:0];
        w_zero       = 1'b0;
        w_inf        = 1'b0;
        w_nan        = 1'b0;
        w_ovf        = 1'b0;
        w_sig        = {1'b1, w_mant};
        w_eeff       = w_exp;
        w_cnt        = 6'd0;

        if (w_exp == 5'd0) begin
            w_sig  = {1'b0, w_mant};
            w_eeff = 5'd1;
            w_zero = (w_mant == 10'd0);
        end else if (w_exp == 5'd31) begin
            w_inf = (w_mant == 10'd0);
            w_nan = (w_mant != 10'd0);
        end

        w_sh = 8'(int'(w_eeff) - 25 + FRAC);

        // A normal significand occupies bits 10+sh..sh after alignment.
        if (w_exp != 5'd0 && w_exp != 5'd31)
            w_ovf = (10 + int'(w_sh) >= W - 1);

        if (w_sh[7]) begin
            w_cnt = (w_sh < -8'sd11) ? 6'd11 : 6'(-w_sh);
        end else begin
            w_cnt = 6'(w_sh);
        end

        w_skip_shift = w_zero || w_inf || w_nan || w_ovf || (w_cnt == 6'd0);
    end

    // NOTE: all state below uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk1) begin
        if (F2X_rest) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_fixed <= '0;
            out_ovf   <= 1'b0;
            out_nan   <= 1'b0;
            r_mag     <= '0;
            r_cnt     <= 6'd0;
            r_left    <= 1'b0;
            r_sign    <= 1'b0;
            r_sat     <= 1'b0;
            r_nan     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        out_ovf  <= 1'b0;
                        out_nan  <= 1'b0;
                        r_mag    <= {{(W-11){1'b0}}, w_sig};
                        r_cnt    <= w_cnt;
                        r_left   <= !w_sh[7];
                        r_sign   <= w_sign;
                        r_sat    <= w_inf || w_ovf;
                        r_nan    <= w_nan;
                        r_state  <= w_skip_shift ? SIGN : SHIFT;
                    end
                end

                SHIFT: begin
                    // Right shifts drop bits, i.e. truncate the magnitude toward zero.
                    r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1)
                        r_state <= SIGN;
                end

                SIGN: begin
                    if (r_nan) begin
                        out_fixed <= '0;
                        out_nan   <= 1'b1;
                    end else if (r_sat) begin
                        out_fixed <= r_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                        out_ovf   <= 1'b1;
                    end else begin
                        out_fixed <= r_sign ? -r_mag : r_mag;
                    end
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_half2fix_seq.sv
// Self-checking bench for half2fix_seq (W=32, FRAC=30): directed corner cases,
// back-pressure, mid-conversion reset and a random stream against a value-level model.
module tb_half2fix_seq;

    localparam int W    = 32;
    localparam int FRAC = 30;

    logic          clk1 = 1'b0;
    logic          F2X_rest;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_half;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_fixed;
    logic          out_ovf;
    logic          out_nan;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] fx;
        logic         ovf;
        logic         nan;
    } exp_t;

    exp_t exp_q[$];

    half2fix_seq #(.W(W), .FRAC(FRAC)) dut (
        .clk1      (clk1),
        .F2X_rest  (F2X_rest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_half   (in_half),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fixed (out_fixed),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Value-level reference: scale the real value by 2^FRAC, truncate toward zero,
    // saturate when the magnitude reaches 2^(W-1). lat counts edges from the accept
    // edge (inclusive) to the edge that raises out_valid; -1 means not checked.
    function automatic void ref_model(input logic [15:0] h, output logic [W-1:0] fx,
                                      output logic ovf, output logic nan, output int lat);
        logic            s;
        int              e;
        int              m;
        int              p;
        longint unsigned sig;
        longint unsigned mag;
        s   = h[15];
        e   = int'(h[14:10]);
        m   = int'(h[9:0]);
        ovf = 1'b0;
        nan = 1'b0;
        fx  = '0;
        lat = 2;
        if (e == 31) begin
            if (m != 0) begin
                nan = 1'b1;
            end else begin
                ovf = 1'b1;
                fx  = s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
            return;
        end
        sig = (e == 0) ? longint'(m) : longint'(1024 + m);
        p   = ((e == 0) ? 1 : e) - 25 + FRAC;
        if (p >= 0) mag = sig << p;
        else        mag = (-p >= 63) ? 64'd0 : (sig >> (-p));
        if (mag >= (64'd1 << (W - 1))) begin
            ovf = 1'b1;
            fx  = s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            return;
        end
        fx = s ? W'(-mag) : W'(mag);
        if (sig == 0) lat = -1;
        else          lat = ((p >= 0) ? p : ((-p > 11) ? 11 : -p)) + 2;
    endfunction

    function automatic logic [15:0] rand_half();
        logic [4:0] e;
        logic [9:0] m;
        e = 5'($urandom_range(31));
        m = ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // One conversion from the idle side, optional back-pressure, then release.
    task automatic run_one(input string tag, input logic [15:0] h, input int hold);
        logic [W-1:0] efx;
        logic         eovf;
        logic         enan;
        int           elat;
        int           edges;
        ref_model(h, efx, eovf, enan, elat);
        @(negedge clk1);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_half  = h;
        @(posedge clk1);
        edges = 1;
        @(negedge clk1);
        in_valid = 1'b0;
        in_half  = 16'($urandom);
        while (!out_valid && edges < 200) begin
            @(posedge clk1);
            edges++;
            @(negedge clk1);
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (elat > 0) check({tag, "_latency"}, 64'(edges), 64'(elat));
        check({tag, "_fixed"}, 64'(out_fixed), 64'(efx));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(eovf));
        check({tag, "_nan"}, 64'(out_nan), 64'(enan));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk1);
            check({tag, "_hold_fixed"}, 64'(out_fixed), 64'(efx));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        check({tag, "_no_bypass"}, 64'(in_ready), 64'd0);
        @(posedge clk1);
        @(negedge clk1);
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [15:0] directed [0:11] = '{
        16'h3C00, 16'h3800, 16'hBE00, 16'h8000, 16'h0001, 16'h5000,
        16'hFC00, 16'h7E00, 16'h3FFF, 16'hBFFF, 16'h03FF, 16'hC000
    };

    initial begin
        int cycles;
        int sent;
        int got;
        int seen;
        bit did_accept;
        exp_t e_item;
        exp_t e_pop;
        int   lat_unused;

        F2X_rest  = 1'b1;
        in_valid  = 1'b0;
        in_half   = 16'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_fixed", 64'(out_fixed), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_out_nan", 64'(out_nan), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        F2X_rest = 1'b0;

        for (int i = 0; i < 12; i++)
            run_one($sformatf("dir%0d_%04h", i, directed[i]), directed[i], 0);

        // Back-pressure then an immediate follow-up sample.
        run_one("stall_3800", 16'h3800, 10);
        run_one("after_stall_3C00", 16'h3C00, 0);

        // Reset five cycles into a long conversion must leave no stale result.
        @(negedge clk1);
        in_valid = 1'b1;
        in_half  = 16'h3C00;
        @(posedge clk1);
        @(negedge clk1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk1);
        @(negedge clk1);
        F2X_rest = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        F2X_rest = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_fixed", 64'(out_fixed), 64'd0);
        check("midrst_flags", 64'({out_ovf, out_nan}), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk1);
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);

        // Random stream: handshakes decided at negedge take effect on the next posedge.
        sent       = 0;
        got        = 0;
        cycles     = 0;
        did_accept = 1'b0;
        while (got < 300 && cycles < 20000) begin
            @(negedge clk1);
            cycles++;
            if (!in_valid || did_accept) begin
                if (sent < 300 && $urandom_range(3) != 0) begin
                    in_valid = 1'b1;
                    in_half  = rand_half();
                end else begin
                    in_valid = 1'b0;
                    in_half  = 16'($urandom);
                end
            end
            did_accept = in_valid && in_ready;
            if (did_accept) begin
                ref_model(in_half, e_item.fx, e_item.ovf, e_item.nan, lat_unused);
                exp_q.push_back(e_item);
                sent++;
            end
            out_ready = 1'($urandom);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_output", 64'd1, 64'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    check($sformatf("stream%0d_fixed", got), 64'(out_fixed), 64'(e_pop.fx));
                    check($sformatf("stream%0d_ovf", got), 64'(out_ovf), 64'(e_pop.ovf));
                    check($sformatf("stream%0d_nan", got), 64'(out_nan), 64'(e_pop.nan));
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_all_received", 64'(got), 64'd300);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
